// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-requester 4-bit ALU with a one-entry registered result.
//            Define ALU_ARBITER_RR_EN for round-robin arbitration;
//            otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_y,
  output logic       res_carry,
  output logic       res_id
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  logic       res_valid_q, res_valid_d;
  logic [3:0] res_y_q, res_y_d;
  logic       res_carry_q, res_carry_d;
  logic       res_id_q, res_id_d;

  logic       can_accept;
  logic       pick1;
  logic       accept;
  logic [3:0] op_a, op_b;
  logic [2:0] op_sel;
  logic [4:0] alu_out;

`ifdef ALU_ARBITER_RR_EN
  logic ptr_q, ptr_d;

  // Pointer holds the last winner; on contention the other requester goes.
  always_comb begin
    pick1 = req1_valid && (!req0_valid || !ptr_q);
    ptr_d = ptr_q;
    if (accept) ptr_d = pick1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    pick1 = req1_valid && !req0_valid;
  end
`endif

  always_comb begin
    can_accept = !res_valid_q || res_ready;
    req0_ready = !rst && can_accept && req0_valid && !pick1;
    req1_ready = !rst && can_accept && pick1;
    accept     = req0_ready || req1_ready;

    op_a   = pick1 ? req1_a   : req0_a;
    op_b   = pick1 ? req1_b   : req0_b;
    op_sel = pick1 ? req1_sel : req0_sel;

    case (op_sel)
      OP_ADD:  alu_out = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB:  alu_out = {1'b0, op_a} - {1'b0, op_b};
      OP_AND:  alu_out = {1'b0, op_a & op_b};
      OP_OR:   alu_out = {1'b0, op_a | op_b};
      OP_XOR:  alu_out = {1'b0, op_a ^ op_b};
      default: alu_out = 5'd0;
    endcase

    // Payload holds after a drain; only an accept overwrites it.
    res_valid_d = res_valid_q && !res_ready;
    res_y_d     = res_y_q;
    res_carry_d = res_carry_q;
    res_id_d    = res_id_q;
    if (accept) begin
      res_valid_d = 1'b1;
      res_y_d     = alu_out[3:0];
      res_carry_d = alu_out[4];
      res_id_d    = pick1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_y_q     <= 4'd0;
      res_carry_q <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_carry_q <= res_carry_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
  assign res_carry = res_carry_q;
  assign res_id    = res_id_q;

endmodule

`default_nettype wire
